sr_divider_5b: RTL
==================

Name: sr_divider_5b

Overview:
- Sequential restoring shift-subtract divider; the inverse datapath of the team's shift-add multiplier.
- Divides an N-bit unsigned dividend by an N-bit unsigned divisor, one quotient bit per clock.
- Board-facing: operands come from slide switches; a push-button starts the operation.
- Runs on the divided (slow) board clock, so each iteration can be watched on LEDs.

Parameters:
- N, 5, operand width; quotient and remainder are also N bits; N >= 2.

Ports:
- CLK  input  1  system clock (driven by the slow clock divider output); all state changes on the rising edge.
- CLR_N  input  1  asynchronous active-low reset.
- BTN  input  1  start button, level, already debounced; an operation starts on a 0->1 transition.
- SW  input  2N  operands: SW[2N-1:N] = dividend, SW[N-1:0] = divisor; sampled only on the start edge.
- QUO  output  N  quotient, registered.
- REM  output  N  remainder, registered.
- BUSY  output  1  high while an iteration is in progress.
- DONE  output  1  high while QUO/REM hold a valid result.
- DIV0  output  1  high with DONE when the divisor was zero.

Behaviour:
- Reset (CLR_N=0, asynchronous): state=IDLE, QUO=0, REM=0, BUSY=0, DONE=0, DIV0=0, internal registers and iteration counter=0, BTN_q=0. Reset mid-operation aborts the operation; no partial result appears.
- Start detect:
  - BTN_q registers BTN every cycle.
  - start = BTN & ~BTN_q.
  - Holding BTN high produces exactly one start.
- States:
  - IDLE: outputs hold. On start: latch dividend into shift register A and divisor into B, clear partial remainder P (N+1 bits), counter=N, go to RUN. If divisor==0, go to FIN instead, with QUO=all ones, REM=dividend, DIV0=1.
  - RUN (BUSY=1), each cycle:
    - {P,A} <= {P,A} shifted left by 1.
    - Trial T = shifted P - {0,B}.
    - If T >= 0: P <= T and A[0] <= 1. Otherwise P stays as shifted and A[0] <= 0.
    - Counter decrements. When the counter goes from 1 to 0, the next state is FIN.
    - Start is ignored in RUN.
  - FIN: entered on the edge after the last iteration.
    - QUO <= A, REM <= P[N-1:0], DONE=1, BUSY=0.
    - On start: clear DONE/DIV0 and act exactly as IDLE on start. The previous QUO/REM are held until the new result is written.
- Latency: the latching edge counts as edge 1. DONE rises after edge N+1 (6 for N=5). The divide-by-zero path takes 2 edges.
- DONE and BUSY are never high together. DIV0 is only high while DONE=1.
- Arithmetic: the trial subtraction is N+1 bits wide, and the sign bit decides the result. REM < divisor always holds for a nonzero divisor.
- SW changes after the start edge have no effect on the operation in progress.

Test Plan:
- Basic divide: N=5, SW={10111,00100} (23/4), BTN pulse -> BUSY high for 5 cycles, then DONE=1, QUO=5, REM=3, DIV0=0. DONE rises exactly 6 edges after the sampling edge.
- Edge cases:
  - 31/1 -> QUO=31, REM=0.
  - 7/9 -> QUO=0, REM=7.
  - 0/5 -> QUO=0, REM=0.
  - 31/31 -> QUO=1, REM=0.
- Divide by zero: SW={01101,00000}, BTN pulse -> after 2 edges DONE=1, DIV0=1, QUO=31, REM=13, BUSY never asserted.
- Button handling:
  - BTN held high for 20 cycles -> exactly one operation.
  - A second BTN edge during RUN is ignored.
  - A new edge in FIN with 20/3 -> DONE drops, and after 6 edges QUO=6, REM=2.
- Operand stability: change SW during RUN -> result reflects only the operands latched at the start edge.
- Reset mid-operation: assert CLR_N low at RUN cycle 3 -> outputs clear immediately, without a clock edge. After release, state is IDLE and there is no DONE until a new BTN edge; the subsequent 23/4 divide is correct.

Source files
------------

// File: rtl/sr_divider_5b.sv
// -----------------------------------------------------------------------------
// sr_divider_5b
// Sequential restoring shift-subtract divider, one quotient bit per clock.
// Intended for a slow board clock so every iteration can be watched on LEDs.
//
// Ports:
//   CLK    in   1   rising-edge clock (slow board clock)
//   CLR_N  in   1   asynchronous active-low reset
//   BTN    in   1   debounced start button; a 0->1 transition starts a divide
//   SW     in   2N  {dividend, divisor}, sampled only on the start edge
//   QUO    out  N   registered quotient
//   REM    out  N   registered remainder
//   BUSY   out  1   iteration in progress
//   DONE   out  1   QUO/REM hold a valid result
//   DIV0   out  1   with DONE: the divisor was zero
// -----------------------------------------------------------------------------
module sr_divider_5b #(
  parameter int N = 5
) (
  input  logic           CLK,
  input  logic           CLR_N,
  input  logic           BTN,
  input  logic [2*N-1:0] SW,
  output logic [N-1:0]   QUO,
  output logic [N-1:0]   REM,
  output logic           BUSY,
  output logic           DONE,
  output logic           DIV0
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ZERO = 2'd2;  // one extra edge for the divide-by-zero result
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          btn_q,   btn_d;
  logic [N-1:0]  a_q,     a_d;     // dividend shifting out, quotient shifting in
  logic [N-1:0]  b_q,     b_d;     // latched divisor
  logic [N:0]    p_q,     p_d;     // partial remainder, one guard bit
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [N-1:0]  quo_q,   quo_d;
  logic [N-1:0]  rem_q,   rem_d;
  logic          div0_q,  div0_d;

  logic          start;
  logic [N:0]    p_sh;
  logic [N-1:0]  a_sh;
  logic [N:0]    trial;
  logic [N:0]    p_nx;
  logic [N-1:0]  a_nx;

  assign start = BTN & ~btn_q;

  // One restoring step: shift {P,A} left, try subtracting B. The shifted P is
  // always below 2*B, so the sign bit of the N+1 bit difference is exact.
  assign p_sh  = {p_q[N-1:0], a_q[N-1]};
  assign a_sh  = {a_q[N-2:0], 1'b0};
  assign trial = p_sh - {1'b0, b_q};

  always_comb begin
    if (trial[N]) begin
      p_nx = p_sh;
      a_nx = a_sh;
    end else begin
      p_nx = trial;
      a_nx = a_sh | N'(1);
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    btn_d   = BTN;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div0_d  = div0_q;

    case (state_q)
      S_IDLE, S_FIN: begin
        // FIN keeps the previous QUO/REM visible until the new result lands.
        if (start) begin
          a_d    = SW[2*N-1:N];
          b_d    = SW[N-1:0];
          p_d    = '0;
          cnt_d  = CW'(N);
          div0_d = 1'b0;
          state_d = (SW[N-1:0] == '0) ? S_ZERO : S_RUN;
        end
      end
      S_RUN: begin
        // BTN is deliberately ignored here.
        a_d   = a_nx;
        p_d   = p_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d   = a_nx;
          rem_d   = p_nx[N-1:0];
          state_d = S_FIN;
        end
      end
      S_ZERO: begin
        quo_d   = '1;
        rem_d   = a_q;
        div0_d  = 1'b1;
        state_d = S_FIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= S_IDLE;
      btn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
    end
  end

  // Status is decoded from the state, so BUSY and DONE can never overlap.
  assign QUO  = quo_q;
  assign REM  = rem_q;
  assign BUSY = (state_q == S_RUN);
  assign DONE = (state_q == S_FIN);
  assign DIV0 = div0_q & DONE;

endmodule
